// File: rtl/note_lane_pkg.sv
// Shared types and helpers for the falling-note engine: game state, score
// width/saturation and lane horizontal placement.
package note_lane_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_e;

  localparam int                  SCORE_W   = 8;
  localparam logic [SCORE_W-1:0]  SCORE_MAX = 8'd255;

  // Left pixel column of lane i.
  function automatic int lane_x_lo(input int i, input int lane_w, input int lane_gap);
    return i * (lane_w + lane_gap);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input int unsigned        b);
    int unsigned sum;
    sum = 32'(a) + b;
    return (sum > 32'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/note_lane_lane.sv
// One colour lane: SLOTS note registers with launch, motion, retire, hit
// matching and the registered per-pixel "note here" compare.
module note_lane
  import note_lane_pkg::*;
#(
  parameter int SLOTS   = 3,
  parameter int Y_W     = 10,
  parameter int Y_MAX   = 520,
  parameter int HALF_H  = 20,
  parameter int HIT_Y   = 460,
  parameter int HIT_WIN = 16,
  parameter int LANE_W  = 200,
  parameter int X_LO    = 0
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             launch,
  input  logic             move,
  input  logic             press,
  input  logic [Y_W-1:0]   pix_x,
  input  logic [Y_W-1:0]   pix_y,
  output logic             hit,
  output logic [SLOTS-1:0] miss,
  output logic             drop,
  output logic             any_active,
  output logic             pix_on
);

  localparam logic [Y_W:0] Y_MAX_W   = Y_MAX[Y_W:0];
  localparam logic [Y_W:0] HALF_H_W  = HALF_H[Y_W:0];
  localparam logic [Y_W:0] HIT_Y_W   = HIT_Y[Y_W:0];
  localparam logic [Y_W:0] HIT_WIN_W = HIT_WIN[Y_W:0];

  logic [SLOTS-1:0] active_q, active_d;
  logic [Y_W-1:0]   pos_q [SLOTS];
  logic [Y_W-1:0]   pos_d [SLOTS];
  logic [SLOTS-1:0] in_win, past_max, in_y, hit_sel, free_sel;
  logic             x_in;

  // Window, retire and pixel tests all use one extra bit so nothing wraps near pos=0.
  always_comb begin
    logic hit_found;
    logic free_found;
    hit_sel    = '0;
    free_sel   = '0;
    hit_found  = 1'b0;
    free_found = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      in_win[s]   = active_q[s] && ({1'b0, pos_q[s]} + HIT_WIN_W >= HIT_Y_W)
                                && ({1'b0, pos_q[s]} <= HIT_Y_W + HIT_WIN_W);
      past_max[s] = active_q[s] && ({1'b0, pos_q[s]} > Y_MAX_W);
      in_y[s]     = active_q[s] && ({1'b0, pix_y} + HALF_H_W >= {1'b0, pos_q[s]})
                                && ({1'b0, pix_y} <= {1'b0, pos_q[s]} + HALF_H_W);
      if (in_win[s] && !hit_found) begin
        hit_sel[s] = 1'b1;
        hit_found  = 1'b1;
      end
      if (!active_q[s] && !free_found) begin
        free_sel[s] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  assign x_in       = (int'(pix_x) >= X_LO) && (int'(pix_x) <= X_LO + LANE_W - 1);
  assign any_active = |active_q;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    active_d = active_q;
    pos_d    = pos_q;
    hit      = press && (|hit_sel);
    miss     = '0;
    drop     = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (press && hit_sel[s]) begin
        active_d[s] = 1'b0;            // a hit beats a same-cycle retire
      end else if (move && active_q[s]) begin
        if (past_max[s]) begin
          active_d[s] = 1'b0;
          miss[s]     = 1'b1;
        end else begin
          pos_d[s] = pos_q[s] + 1'b1;
        end
      end
      // Free slot is chosen on pre-update occupancy, so it never collides with a retire.
      if (launch && free_sel[s]) begin
        active_d[s] = 1'b1;
        pos_d[s]    = '0;
      end
    end
    if (launch && !(|free_sel)) drop = 1'b1;
  end

  // NOTE: the slot array is small and must read as empty after reset, so it is reset explicitly.
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      active_q <= '0;
      for (int s = 0; s < SLOTS; s++) pos_q[s] <= '0;
      pix_on   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      active_q <= active_d;
      pos_q    <= pos_d;
      pix_on   <= x_in && (|in_y);
    end
  end

endmodule

// File: rtl/note_lane_engine.sv
// Falling-note engine top: game FSM, pattern fetch pacing, lane array and
// saturating hit/miss scores.
module note_lane_engine
  import note_lane_pkg::*;
#(
  parameter int LANES    = 3,
  parameter int SLOTS    = 3,
  parameter int Y_W      = 10,
  parameter int Y_MAX    = 520,
  parameter int NOTE_GAP = 32,
  parameter int HALF_H   = 20,
  parameter int LANE_W   = 200,
  parameter int LANE_GAP = 20,
  parameter int HIT_Y    = 460,
  parameter int HIT_WIN  = 16
) (
  input  logic               clk,
  input  logic               reset_bar,
  input  logic               step_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               note_valid,
  input  logic [LANES-1:0]   note_bits,
  input  logic               note_last,
  output logic               note_ready,
  input  logic [LANES-1:0]   lane_btn,
  input  logic [Y_W-1:0]     pix_x,
  input  logic [Y_W-1:0]     pix_y,
  output logic [LANES-1:0]   lane_pix,
  output logic [SCORE_W-1:0] hit_count,
  output logic [SCORE_W-1:0] miss_count,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam int               GAP_W    = (NOTE_GAP > 1) ? $clog2(NOTE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(NOTE_GAP - 1);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q;
  logic             ready_q, last_q, overflow_q;
  logic [SCORE_W-1:0] hit_q, miss_q;

  logic             play, move, xfer, start_play, gap_wrap, all_idle;
  logic [LANES-1:0] hit_vec, drop_vec, active_vec;
  logic [SLOTS-1:0] miss_lane [LANES];
  int unsigned      hit_sum, miss_sum;

  assign play       = (state_q == PLAY);
  assign move       = play && step_tick && !pause;
  assign note_ready = ready_q && play && !pause;
  assign xfer       = note_valid && note_ready;
  assign start_play = (state_q == IDLE) && start;
  assign gap_wrap   = (gap_q == GAP_LAST);
  assign all_idle   = !(|active_vec);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    note_lane #(
      .SLOTS  (SLOTS),
      .Y_W    (Y_W),
      .Y_MAX  (Y_MAX),
      .HALF_H (HALF_H),
      .HIT_Y  (HIT_Y),
      .HIT_WIN(HIT_WIN),
      .LANE_W (LANE_W),
      .X_LO   (lane_x_lo(i, LANE_W, LANE_GAP))
    ) u_lane (
      .clk       (clk),
      .reset_bar (reset_bar),
      .launch    (xfer && note_bits[i]),
      .move      (move),
      .press     (play && lane_btn[i]),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .hit       (hit_vec[i]),
      .miss      (miss_lane[i]),
      .drop      (drop_vec[i]),
      .any_active(active_vec[i]),
      .pix_on    (lane_pix[i])
    );
  end

  always_comb begin
    hit_sum  = $countones(hit_vec);
    miss_sum = 0;
    for (int i = 0; i < LANES; i++) miss_sum += $countones(miss_lane[i]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PLAY;
      PLAY:    if (last_q && all_idle) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_bar) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      gap_q      <= '0;
      ready_q    <= 1'b0;
      last_q     <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start_play) begin
        gap_q   <= '0;
        ready_q <= 1'b0;
        last_q  <= 1'b0;
        hit_q   <= '0;
        miss_q  <= '0;
      end else begin
        if (move) gap_q <= gap_wrap ? '0 : gap_q + 1'b1;
        if (xfer) begin
          ready_q <= 1'b0;
          if (note_last) last_q <= 1'b1;
        end
        // Once the final pattern is in, the fetch window never reopens.
        if (move && gap_wrap && !last_q && !(xfer && note_last)) ready_q <= 1'b1;
        hit_q  <= sat_add(hit_q, hit_sum);
        miss_q <= sat_add(miss_q, miss_sum);
      end
      if (|drop_vec) overflow_q <= 1'b1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign overflow   = overflow_q;
  assign busy       = play;
  assign done       = (state_q == DONE);

endmodule
